// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter:
// FSM state encoding and the grant-source encoding used by round-robin.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_src_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction and a data requester.
// Ports: clk, reset (async, active-low); inst_* and data_* requester
// ports; mem_* shared memory port. Payload is not latched: requesters
// hold request and payload until their resp.
// Option: ARB_ROUND_ROBIN_EN grants the requester not served last on
// simultaneous requests; otherwise data always wins.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_read,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_resp,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [DATA_W/8-1:0] data_mbe,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_resp,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_mbe,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t state_q, state_d;
    logic       data_req;
    logic       both_to_data;

    assign data_req = data_read | data_write;

`ifdef ARB_ROUND_ROBIN_EN
    grant_src_t last_q, last_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= GNT_INST;
        end else begin
            last_q <= last_d;
        end
    end

    // Updated only when a transaction actually completes.
    always_comb begin
        last_d = last_q;
        if (mem_resp && state_q == INST) begin
            last_d = GNT_INST;
        end else if (mem_resp && state_q == DATA) begin
            last_d = GNT_DATA;
        end
    end

    assign both_to_data = (last_q == GNT_INST);
`else
    assign both_to_data = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (data_req && inst_read) begin
                    state_d = both_to_data ? DATA : INST;
                end else if (data_req) begin
                    state_d = DATA;
                end else if (inst_read) begin
                    state_d = INST;
                end
            end
            INST, DATA: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces IDLE asynchronously, so every mem_* output and both
    // resps drop to 0 immediately through this mux.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_mbe   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        inst_resp = 1'b0;
        data_resp = 1'b0;
        unique case (state_q)
            INST: begin
                mem_read  = 1'b1;
                mem_mbe   = '1;
                mem_addr  = inst_addr;
                inst_resp = mem_resp;
            end
            DATA: begin
                mem_read  = data_read;
                mem_write = data_write;
                mem_mbe   = data_mbe;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
                data_resp = mem_resp;
            end
            default: ;
        endcase
    end

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // Read and write together is passed through but flagged.
    illegal_rw_a: assert property (
        @(posedge clk) disable iff (!reset)
        !(data_read && data_write)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level owner model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          inst_read;
    logic [AW-1:0] inst_addr;
    logic          inst_resp;
    logic [DW-1:0] inst_rdata;
    logic          data_read;
    logic          data_write;
    logic [BW-1:0] data_mbe;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_resp;
    logic [DW-1:0] data_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [BW-1:0] mem_mbe;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_resp;
    logic [DW-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    initial forever #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_read  (inst_read),
        .inst_addr  (inst_addr),
        .inst_resp  (inst_resp),
        .inst_rdata (inst_rdata),
        .data_read  (data_read),
        .data_write (data_write),
        .data_mbe   (data_mbe),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_resp  (data_resp),
        .data_rdata (data_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_mbe    (mem_mbe),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata)
    );

    task automatic idle_inputs();
        inst_read  = 1'b0;
        inst_addr  = '0;
        data_read  = 1'b0;
        data_write = 1'b0;
        data_mbe   = '0;
        data_addr  = '0;
        data_wdata = '0;
        mem_resp   = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset     = 1'b0;
        inst_read = 1'b1;
        data_read = 1'b1;
        mem_resp  = 1'b1;
        mem_rdata = 32'hA5A5_0001;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_read, mem_write, mem_mbe, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mem: got %b %b %h %h %h want all 0",
                     mem_read, mem_write, mem_mbe, mem_addr, mem_wdata);
        end
        checks++;
        if ({inst_resp, data_resp} !== 2'b00) begin
            errors++;
            $display("FAIL reset_resp: got %b%b want 00", inst_resp, data_resp);
        end
        checks++;
        if (inst_rdata !== 32'hA5A5_0001 || data_rdata !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL reset_rdata: got %h %h want a5a50001",
                     inst_rdata, data_rdata);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_inst_read();
        @(negedge clk);
        inst_read = 1'b1;
        inst_addr = 32'h60;
        #1;
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL inst_latency: mem_read got %b want 0", mem_read);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                mem_resp  = 1'b1;
                mem_rdata = 32'h13;
            end
            #1;
            checks++;
            if ({mem_read, mem_write, mem_addr, mem_mbe, mem_wdata} !==
                {1'b1, 1'b0, 32'h60, 4'hF, 32'h0}) begin
                errors++;
                $display("FAIL inst_grant c%0d: got %b %b %h %h %h want 1 0 60 f 0",
                         c, mem_read, mem_write, mem_addr, mem_mbe, mem_wdata);
            end
            checks++;
            if ({inst_resp, data_resp} !== {(c == 2), 1'b0}) begin
                errors++;
                $display("FAIL inst_resp c%0d: got %b%b want %b0",
                         c, inst_resp, data_resp, (c == 2));
            end
        end
        checks++;
        if (inst_rdata !== 32'h13) begin
            errors++;
            $display("FAIL inst_rdata: got %h want 13", inst_rdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({mem_read, inst_resp} !== 2'b00) begin
            errors++;
            $display("FAIL inst_idle: got %b%b want 00", mem_read, inst_resp);
        end
    endtask

    task automatic test_data_write();
        int pulses;
        pulses = 0;
        @(negedge clk);
        data_write = 1'b1;
        data_addr  = 32'h100;
        data_wdata = 32'hDEAD_BEEF;
        data_mbe   = 4'h3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_resp = (c == 1);
            if (c == 2) data_write = 1'b0;
            #1;
            if (data_resp === 1'b1) pulses++;
            if (c < 2) begin
                checks++;
                if ({mem_read, mem_write, mem_addr, mem_mbe, mem_wdata} !==
                    {1'b0, 1'b1, 32'h100, 4'h3, 32'hDEAD_BEEF}) begin
                    errors++;
                    $display("FAIL data_wr c%0d: got %b %b %h %h %h want 0 1 100 3 deadbeef",
                             c, mem_read, mem_write, mem_addr, mem_mbe, mem_wdata);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL data_resp_pulses: got %0d want 1", pulses);
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        bit inst_first;
        bit srv_inst;
`ifdef ARB_ROUND_ROBIN_EN
        inst_first = 1'b1;
`else
        inst_first = 1'b0;
`endif
        @(negedge clk);
        inst_read = 1'b1;
        inst_addr = 32'h40;
        data_read = 1'b1;
        data_addr = 32'h200;
        data_mbe  = 4'hF;
        for (int t = 0; t < 2; t++) begin
            srv_inst = (t == 0) ? inst_first : !inst_first;
            @(negedge clk);
            mem_resp  = 1'b1;
            mem_rdata = 32'h1000 + t;
            #1;
            checks++;
            if ({mem_read, mem_write, mem_addr} !==
                {1'b1, 1'b0, (srv_inst ? 32'h40 : 32'h200)}) begin
                errors++;
                $display("FAIL simul_grant t%0d: got %b %b %h want inst=%b",
                         t, mem_read, mem_write, mem_addr, srv_inst);
            end
            checks++;
            if ({inst_resp, data_resp} !== {srv_inst, !srv_inst}) begin
                errors++;
                $display("FAIL simul_resp t%0d: got %b%b want %b%b",
                         t, inst_resp, data_resp, srv_inst, !srv_inst);
            end
            @(negedge clk);
            mem_resp = 1'b0;
            if (srv_inst) inst_read = 1'b0;
            else data_read = 1'b0;
            #1;
            checks++;
            if ({mem_read, mem_write, inst_resp, data_resp} !== 4'b0000) begin
                errors++;
                $display("FAIL simul_idle t%0d: got %b%b%b%b want 0000",
                         t, mem_read, mem_write, inst_resp, data_resp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        inst_read = 1'b1;
        inst_addr = 32'h80;
        @(negedge clk);
        #1;
        checks++;
        if ({mem_read, mem_addr} !== {1'b1, 32'h80}) begin
            errors++;
            $display("FAIL rst_mid_grant: got %b %h want 1 80", mem_read, mem_addr);
        end
        #2;
        reset    = 1'b0;
        mem_resp = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_write, mem_mbe, mem_addr, mem_wdata,
             inst_resp, data_resp} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: got %b %b %h %h %h %b %b want all 0",
                     mem_read, mem_write, mem_mbe, mem_addr, mem_wdata,
                     inst_resp, data_resp);
        end
        @(negedge clk);
        reset     = 1'b1;
        inst_read = 1'b0;
        #1;
        checks++;
        if ({mem_read, inst_resp} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_release: got %b%b want 00", mem_read, inst_resp);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({mem_read, inst_resp} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_after: got %b%b want 00", mem_read, inst_resp);
        end
        idle_inputs();
    endtask

    task automatic test_idle_resp();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_resp = 1'b1;
            #1;
            checks++;
            if ({mem_read, mem_write, inst_resp, data_resp} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_resp c%0d: got %b%b%b%b want 0000",
                         c, mem_read, mem_write, inst_resp, data_resp);
            end
        end
        @(negedge clk);
        mem_resp  = 1'b0;
        inst_read = 1'b1;
        inst_addr = 32'h4;
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_addr, inst_resp} !== {1'b1, 32'h4, 1'b1}) begin
            errors++;
            $display("FAIL idle_then_inst: got %b %h %b want 1 4 1",
                     mem_read, mem_addr, inst_resp);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // Model: who owns the port (0 none, 1 inst, 2 data) and who was last
    // served; expected outputs follow from the owner alone.
    task automatic test_random();
        int            own;
        bit            last_data;
        bit            ipend, dpend, dwr, idone, ddone;
        logic [31:0]   r;
        logic          e_rd, e_wr, e_ir, e_dr;
        logic [AW-1:0] e_addr;
        logic [BW-1:0] e_mbe;
        logic [DW-1:0] e_wdata;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        own = 0;
        last_data = 1'b0;
        ipend = 1'b0;
        dpend = 1'b0;
        dwr = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (!ipend && $urandom_range(3) == 0) begin
                ipend = 1'b1;
                inst_addr = $urandom;
            end
            if (!dpend && $urandom_range(3) == 0) begin
                dpend = 1'b1;
                r = $urandom;
                dwr = r[0];
                data_mbe = r[7:4];
                data_addr = $urandom;
                data_wdata = $urandom;
            end
            inst_read  = ipend;
            data_read  = dpend && !dwr;
            data_write = dpend && dwr;
            mem_resp   = ($urandom_range(2) == 0);
            mem_rdata  = $urandom;
            #1;
            e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_mbe = '0; e_wdata = '0;
            e_ir = 1'b0; e_dr = 1'b0;
            if (own == 1) begin
                e_rd = 1'b1; e_addr = inst_addr; e_mbe = '1; e_ir = mem_resp;
            end else if (own == 2) begin
                e_rd = !dwr; e_wr = dwr; e_addr = data_addr;
                e_mbe = data_mbe; e_wdata = data_wdata; e_dr = mem_resp;
            end
            checks++;
            if ({mem_read, mem_write, mem_addr, mem_mbe, mem_wdata} !==
                {e_rd, e_wr, e_addr, e_mbe, e_wdata}) begin
                errors++;
                $display("FAIL rand_mem n%0d: got %b %b %h %h %h want %b %b %h %h %h",
                         n, mem_read, mem_write, mem_addr, mem_mbe, mem_wdata,
                         e_rd, e_wr, e_addr, e_mbe, e_wdata);
            end
            checks++;
            if ({inst_resp, data_resp} !== {e_ir, e_dr}) begin
                errors++;
                $display("FAIL rand_resp n%0d: got %b%b want %b%b",
                         n, inst_resp, data_resp, e_ir, e_dr);
            end
            checks++;
            if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin
                errors++;
                $display("FAIL rand_rdata n%0d: got %h %h want %h",
                         n, inst_rdata, data_rdata, mem_rdata);
            end
            idone = (own == 1) && mem_resp;
            ddone = (own == 2) && mem_resp;
            @(posedge clk);
            if (own == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (ipend && dpend) own = last_data ? 1 : 2;
                else if (dpend) own = 2;
                else if (ipend) own = 1;
`else
                if (dpend) own = 2;
                else if (ipend) own = 1;
`endif
            end else if (mem_resp) begin
                last_data = (own == 2);
                own = 0;
            end
            if (idone) ipend = 1'b0;
            if (ddone) dpend = 1'b0;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_inst_read();
        test_data_write();
        test_simultaneous();
        test_reset_mid();
        test_idle_resp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width for all ports.
REQ-002 Parameter: DATA_W, 32, data width; the mbe width SHALL be DATA_W/8.
REQ-003 Port: clk  in  1  sole clock, all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Ports: inst_read in 1, inst_addr in ADDR_W; inst_resp out 1, inst_rdata out DATA_W: instruction requester.
REQ-006 Ports: data_read in 1, data_write in 1, data_mbe in DATA_W/8, data_addr in ADDR_W, data_wdata in DATA_W; data_resp out 1, data_rdata out DATA_W: data requester.
REQ-007 Ports: mem_read out 1, mem_write out 1, mem_mbe out DATA_W/8, mem_addr out ADDR_W, mem_wdata out DATA_W; mem_resp in 1, mem_rdata in DATA_W: shared memory port.

Function
REQ-008 The block SHALL share one memory port between the instruction and data requesters, one transaction at a time.
REQ-009 FSM states SHALL be IDLE, INST, DATA.
- IDLE -> DATA if data_read|data_write; else -> INST if inst_read; else stay.
- INST/DATA -> IDLE on the cycle mem_resp=1; else stay.
REQ-010 The arbitration decision SHALL be taken in IDLE and registered, so the grant is visible on mem_* one cycle after the request is seen in IDLE.
REQ-011 In IDLE, mem_read and mem_write SHALL be 0; mem_addr, mem_wdata and mem_mbe SHALL be 0.
REQ-012 In INST: mem_read=1, mem_write=0, mem_addr=inst_addr, mem_mbe=all ones, mem_wdata=0.
REQ-013 In DATA: mem_read=data_read, mem_write=data_write, mem_addr=data_addr, mem_mbe=data_mbe, mem_wdata=data_wdata.
REQ-014 inst_resp SHALL equal mem_resp AND state==INST; data_resp SHALL equal mem_resp AND state==DATA; both are combinational with no added latency.
REQ-015 inst_rdata and data_rdata SHALL both be driven from mem_rdata unconditionally.
REQ-016 Requesters SHALL hold their request and payload stable until their resp; the arbiter does not latch the payload.
REQ-017 Minimum turnaround SHALL be one IDLE cycle between consecutive transactions.
REQ-018 Simultaneous requests in IDLE SHALL grant data; the loser waits with its request held.
REQ-019 mem_resp received in IDLE SHALL be ignored: no resp is forwarded and the state is unchanged.
REQ-020 data_read and data_write both high is illegal; the arbiter SHALL pass both through unchanged (an assertion flags it).
REQ-021 A requester deasserting before its resp is illegal; the FSM SHALL remain in its state until mem_resp.

Reset
REQ-022 reset low SHALL immediately force IDLE and clear the last-grant register, regardless of the clock.
REQ-023 During reset all outputs SHALL be 0, except the rdata outputs, which follow mem_rdata.
REQ-024 Reset mid-transaction SHALL abandon it, with no resp forwarded; the requester must reissue.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests in IDLE SHALL grant the requester not served last (a 1-bit last-grant register, updated on each completed transaction, reset value meaning INST was last).
- When undefined, fixed data priority (REQ-018) applies and no last-grant register exists.

Structure
REQ-026 A shared package SHALL hold the arb_state_t enum (IDLE, INST, DATA) and the grant-source encoding.
REQ-027 No sub-module is required; the FSM and the output mux SHALL live in mem_port_arbiter.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- inst_read=1, addr 0x60 only; mem_resp after 3 cycles -> mem_read=1, mem_addr=0x60, mem_mbe=0xF from cycle 1; inst_resp=1 with rdata 0x13 in resp cycle; IDLE next cycle.
- data_write=1, addr 0x100, wdata 0xDEADBEEF, mbe 0x3 -> mem_write=1 carries those exact values; data_resp pulses once; mem_read=0.
- inst_read and data_read high together, default build -> DATA served first, then IDLE for one cycle, then INST served; no resp crossover.
- Same stimulus, ARB_ROUND_ROBIN_EN defined, last grant = DATA -> INST served first.
- Grant INST, assert reset low mid-wait -> outputs are 0 asynchronously; after release, IDLE and no inst_resp.
- mem_resp=1 pulsed while IDLE with no requests -> inst_resp=0, data_resp=0, state stays IDLE.
